// File: rtl/lutram_march_tester.sv
// Self-checking distributed-RAM march tester: clear, then NUM_PASSES write/verify sweeps
// at a divided step rate, with a saturating mismatch count and a sticky pass/fail result.
module lutram_march_tester #(
  parameter int          A_WIDTH         = 8,
  parameter int          D_WIDTH         = 1,
  parameter int          PATTERN         = 0,
  parameter int          NUM_PASSES      = 2,
  parameter logic [31:0] DIV_COUNTER_END = 32'h00FFFFFF,
  parameter int          ERR_W           = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               inject_i,
  output logic [D_WIDTH-1:0] q_o,
  output logic [A_WIDTH-1:0] addr_o,
  output logic [2:0]         state_o,
  output logic [1:0]         pass_idx_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [ERR_W-1:0]   err_count_o,
  output logic [A_WIDTH-1:0] first_err_addr_o
);

  typedef enum logic [2:0] {
    ST_INITIAL = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_WRITE   = 3'd2,
    ST_VERIFY  = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  localparam logic [1:0] LAST_PASS = 2'(NUM_PASSES - 1);

  state_e               state_q, state_d;
  logic [31:0]          div_q, div_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]           pass_q, pass_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [A_WIDTH-1:0]   first_q, first_d;
  logic                 done_q, done_d;
  logic                 pass_ok_q, pass_ok_d;

  logic                 tick;
  logic                 addr_max;
  logic                 mismatch;
  logic                 we;
  logic [D_WIDTH-1:0]   wdata;
  logic [D_WIDTH-1:0]   exp_data;
  logic [D_WIDTH-1:0]   rdata;
  logic [D_WIDTH-1:0]   mem_q [0:(1<<A_WIDTH)-1];

  function automatic logic [D_WIDTH-1:0] expected_word(input logic [A_WIDTH-1:0] a,
                                                       input logic [1:0]         p);
    logic [A_WIDTH+D_WIDTH-1:0] ext;
    logic [D_WIDTH-1:0]         base;
    ext = {{D_WIDTH{1'b0}}, a};
    case (PATTERN)
      0:       base = {D_WIDTH{a[0]}};
      1:       base = ext[D_WIDTH-1:0];
      default: base = ~ext[D_WIDTH-1:0];
    endcase
    return base ^ {D_WIDTH{p[0]}};
  endfunction

  always_comb begin
    tick  = (div_q >= DIV_COUNTER_END);
    div_d = tick ? '0 : div_q + 32'd1;
  end

  assign addr_max = (addr_q == '1);
  assign exp_data = expected_word(addr_q, pass_q);
  assign rdata    = mem_q[addr_q];
  assign mismatch = (state_q == ST_VERIFY) && (rdata != exp_data);

  // State register plus the datapath flops it steers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_INITIAL;
      div_q     <= '0;
      addr_q    <= '0;
      pass_q    <= '0;
      err_q     <= '0;
      first_q   <= '0;
      done_q    <= 1'b0;
      pass_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      addr_q    <= addr_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      first_q   <= first_d;
      done_q    <= done_d;
      pass_ok_q <= pass_ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        ST_INITIAL: state_d = ST_CLEAR;
        ST_CLEAR:   if (addr_max) state_d = ST_WRITE;
        ST_WRITE:   if (addr_max) state_d = ST_VERIFY;
        ST_VERIFY:  if (addr_max) state_d = (pass_q < LAST_PASS) ? ST_WRITE : ST_FINISH;
        ST_FINISH:  state_d = ST_FINISH;
        default:    state_d = ST_INITIAL;
      endcase
    end
  end

  // Address increments wrap max->0 on their own, so phase changes need no explicit clear.
  always_comb begin
    addr_d  = addr_q;
    pass_d  = pass_q;
    err_d   = err_q;
    first_d = first_q;
    if (tick) begin
      case (state_q)
        ST_CLEAR, ST_WRITE: addr_d = addr_q + 1'b1;
        ST_VERIFY: begin
          addr_d = addr_q + 1'b1;
          if (addr_max && (pass_q < LAST_PASS)) pass_d = pass_q + 1'b1;
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (err_q == '0) first_d = addr_q;
          end
        end
        default: addr_d = '0;
      endcase
    end
    done_d    = (state_d == ST_FINISH);
    pass_ok_d = done_d && (err_d == '0);
  end

  always_comb begin
    we       = 1'b0;
    wdata    = '0;
    if (tick) begin
      case (state_q)
        ST_CLEAR: we = 1'b1;
        ST_WRITE: begin
          we       = 1'b1;
          wdata    = exp_data;
          wdata[0] = exp_data[0] ^ inject_i;
        end
        default: we = 1'b0;
      endcase
    end
  end

  // RAM contents deliberately survive reset; only writes are suppressed during it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && we) mem_q[addr_q] <= wdata;
  end

  assign q_o              = rdata;
  assign addr_o           = addr_q;
  assign state_o          = state_q;
  assign pass_idx_o       = pass_q;
  assign done_o           = done_q;
  assign pass_o           = pass_ok_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_lutram_march_tester.sv
// Bench for lutram_march_tester: three parameterisations driven through a shared run task,
// checked against a phase-schedule model and an injection table.
module tb_lutram_march_tester;

  localparam int AW = 4;
  localparam int DW = 4;
  localparam int N  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst = 3'b111;
  logic [2:0] inj = 3'b000;

  logic [DW-1:0] q_a, q_b, q_c;
  logic [AW-1:0] addr_a, addr_b, addr_c, fe_a, fe_b, fe_c;
  logic [2:0]    st_a, st_b, st_c;
  logic [1:0]    pi_a, pi_b, pi_c;
  logic          done_a, done_b, done_c, pass_a, pass_b, pass_c;
  logic [15:0]   err_a, err_b;
  logic [1:0]    err_c;

  lutram_march_tester #(.A_WIDTH(AW), .D_WIDTH(DW), .PATTERN(1), .NUM_PASSES(2),
                        .DIV_COUNTER_END(32'd0), .ERR_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst[0]), .inject_i(inj[0]), .q_o(q_a), .addr_o(addr_a),
    .state_o(st_a), .pass_idx_o(pi_a), .done_o(done_a), .pass_o(pass_a),
    .err_count_o(err_a), .first_err_addr_o(fe_a));

  lutram_march_tester #(.A_WIDTH(AW), .D_WIDTH(DW), .PATTERN(0), .NUM_PASSES(1),
                        .DIV_COUNTER_END(32'd0), .ERR_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst[1]), .inject_i(inj[1]), .q_o(q_b), .addr_o(addr_b),
    .state_o(st_b), .pass_idx_o(pi_b), .done_o(done_b), .pass_o(pass_b),
    .err_count_o(err_b), .first_err_addr_o(fe_b));

  lutram_march_tester #(.A_WIDTH(AW), .D_WIDTH(DW), .PATTERN(2), .NUM_PASSES(2),
                        .DIV_COUNTER_END(32'd3), .ERR_W(2)) dut_c (
    .clk_i(clk), .rst_i(rst[2]), .inject_i(inj[2]), .q_o(q_c), .addr_o(addr_c),
    .state_o(st_c), .pass_idx_o(pi_c), .done_o(done_c), .pass_o(pass_c),
    .err_count_o(err_c), .first_err_addr_o(fe_c));

  int            sel = 0;
  logic [DW-1:0] o_q;
  logic [AW-1:0] o_addr, o_fe;
  logic [2:0]    o_st;
  logic [1:0]    o_pi;
  logic          o_done, o_pass;
  logic [15:0]   o_err;

  always_comb begin
    case (sel)
      0: begin o_q = q_a; o_addr = addr_a; o_fe = fe_a; o_st = st_a; o_pi = pi_a;
               o_done = done_a; o_pass = pass_a; o_err = err_a; end
      1: begin o_q = q_b; o_addr = addr_b; o_fe = fe_b; o_st = st_b; o_pi = pi_b;
               o_done = done_b; o_pass = pass_b; o_err = err_b; end
      default: begin o_q = q_c; o_addr = addr_c; o_fe = fe_c; o_st = st_c; o_pi = pi_c;
               o_done = done_c; o_pass = pass_c; o_err = {14'd0, err_c}; end
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Which (pass, addr) writes get bit 0 flipped.
  bit inj_tab [4][N];

  function automatic logic [3:0] exp_word(input int mode, input int a, input int p);
    logic [3:0] av;
    logic [3:0] v;
    av = 4'(a);
    case (mode)
      0:       v = av[0] ? 4'hF : 4'h0;
      1:       v = av;
      default: v = ~av;
    endcase
    if (p % 2 == 1) v = ~v;
    return v;
  endfunction

  // Expected state/addr/pass after t ticks since reset, from the phase layout.
  task automatic sched(input int t, input int np, output int st, output int ad, output int ps);
    int k;
    int r;
    st = 0; ad = 0; ps = 0;
    if (t > 0) begin
      k = t - 1;
      if (k < N) begin
        st = 1; ad = k;
      end else begin
        k = k - N;
        if (k >= 2 * N * np) begin
          st = 4; ad = 0; ps = np - 1;
        end else begin
          ps = k / (2 * N);
          r  = k % (2 * N);
          if (r < N) begin st = 2; ad = r; end
          else       begin st = 3; ad = r - N; end
        end
      end
    end
  endtask

  task automatic expect_err(input int st, input int ad, input int ps, input int errmax,
                            output int cnt, output int first);
    bit verified;
    cnt = 0; first = 0;
    for (int p = 0; p < 4; p++) begin
      for (int a = 0; a < N; a++) begin
        verified = (st == 4) || (p < ps) || (p == ps && st == 3 && a < ad);
        if (verified && inj_tab[p][a]) begin
          if (cnt == 0) first = a;
          cnt++;
        end
      end
    end
    if (cnt > errmax) cnt = errmax;
  endtask

  // inj_mode: 0 none, 1 every write, 2 only pass-0 addr 5, 3 random
  task automatic run(input int s, input int mode, input int np, input int div, input int errmax,
                     input int inj_mode, input int abort_at);
    int total_edges;
    int t, st, ad, ps, ecnt, efirst;
    logic [3:0] qexp;
    for (int p = 0; p < 4; p++)
      for (int a = 0; a < N; a++)
        case (inj_mode)
          1:       inj_tab[p][a] = (p < np);
          2:       inj_tab[p][a] = (p == 0 && a == 5);
          3:       inj_tab[p][a] = (p < np) && ($urandom_range(0, 3) == 0);
          default: inj_tab[p][a] = 1'b0;
        endcase
    sel = s;
    rst[s] = 1'b1;
    inj[s] = 1'b0;
    @(posedge clk); #1;
    rst[s] = 1'b0;
    check_eq("reset state", 32'(o_st), 32'd0);
    check_eq("reset addr", 32'(o_addr), 32'd0);
    check_eq("reset pass_idx", 32'(o_pi), 32'd0);
    check_eq("reset done", 32'(o_done), 32'd0);
    check_eq("reset pass", 32'(o_pass), 32'd0);
    check_eq("reset err", 32'(o_err), 32'd0);
    check_eq("reset first_err", 32'(o_fe), 32'd0);

    total_edges = (1 + N * (1 + 2 * np)) * (div + 1);
    for (int c = 0; c < total_edges; c++) begin
      t = c / (div + 1);
      sched(t, np, st, ad, ps);
      expect_err(st, ad, ps, errmax, ecnt, efirst);
      check_eq("state", 32'(o_st), 32'(st));
      check_eq("addr", 32'(o_addr), 32'(ad));
      check_eq("pass_idx", 32'(o_pi), 32'(ps));
      check_eq("done early", 32'(o_done), 32'd0);
      check_eq("pass early", 32'(o_pass), 32'd0);
      check_eq("err running", 32'(o_err), 32'(ecnt));
      check_eq("first_err running", 32'(o_fe), 32'(efirst));
      if (st == 3) begin
        qexp = exp_word(mode, ad, ps);
        qexp[0] = qexp[0] ^ inj_tab[ps][ad];
        check_eq("q_o verify", 32'(o_q), 32'(qexp));
      end
      if (c == abort_at) return;
      inj[s] = (st == 2) ? inj_tab[ps][ad] : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end

    expect_err(4, 0, np - 1, errmax, ecnt, efirst);
    for (int h = 0; h < 4; h++) begin
      check_eq("finish state", 32'(o_st), 32'd4);
      check_eq("finish addr", 32'(o_addr), 32'd0);
      check_eq("finish pass_idx", 32'(o_pi), 32'(np - 1));
      check_eq("finish done", 32'(o_done), 32'd1);
      check_eq("finish pass", 32'(o_pass), 32'(ecnt == 0));
      check_eq("finish err", 32'(o_err), 32'(ecnt));
      check_eq("finish first_err", 32'(o_fe), 32'(efirst));
      inj[s] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    inj[s] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    run(0, 1, 2, 0, 65535, 0, -1);   // clean run, FINISH after 81 edges
    run(0, 1, 2, 0, 65535, 1, -1);   // inject every write: 32 errors
    run(0, 1, 2, 0, 65535, 2, -1);   // single pass-0 fault at addr 5
    run(0, 1, 2, 0, 65535, 3, 43);   // random faults, aborted mid-VERIFY
    run(0, 1, 2, 0, 65535, 0, -1);   // rerun after abort
    run(1, 0, 1, 0, 65535, 0, -1);   // PATTERN 0, one pass, 49 edges
    run(1, 0, 1, 0, 65535, 3, -1);
    run(2, 2, 2, 3, 3, 3, -1);       // divided tick, 2-bit saturating counter
    run(2, 2, 2, 3, 3, 1, -1);
    run(2, 2, 2, 3, 3, 0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
